uart_tx_frame_arbiter: RTL and testbench

//  Shares the single UART transmit core between N_CH channel TX FIFOs. It picks one channel at a time
//  by round-robin and sends that channel's frame as a sequence of bytes.

---
 rtl/uart_tx_frame_arbiter.sv | 143 ++++++++++++++
 tb/tb_uart_tx_frame_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_arbiter.sv
// Round-robin arbiter that shares one UART transmit core between N_CH channel FIFOs.
// Each grant sends one frame: [address byte] payload bytes [end byte].
module uart_tx_frame_arbiter #(
    parameter int          N_CH      = 4,
    parameter int          MAX_BURST = 16,
    parameter logic [7:0]  ADDR_BASE = 8'h80,
    parameter logic [7:0]  END_BYTE  = 8'h0A,
    localparam int         CH_W      = $clog2(N_CH),
    localparam int         CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic              glb_clk,
    input  logic              glb_rst,
    input  logic              Cfg_ctrl_Tx_en,
    input  logic              Cfg_ctrl_protocal_en,
    input  logic [N_CH-1:0]   ch_empty,
    input  logic [N_CH*8-1:0] ch_rdata,
    output logic [N_CH-1:0]   ch_r_en,
    input  logic              core_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic [CH_W-1:0]   cur_ch,
    output logic [1:0]        dbg_state_o
);

    // Byte handshake: a byte moves on every cycle where tx_valid & core_ready;
    // while tx_valid is high and core_ready is low, tx_data does not change.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ADDR    = 2'd1,
        S_PAYLOAD = 2'd2,
        S_ENDF    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mode_q, mode_d;

    logic [N_CH-1:0]   req;
    logic              found;
    logic [CH_W-1:0]   win;
    logic [CH_W:0]     cand;
    logic              head_empty;
    logic [7:0]        head_data;

    assign req        = Cfg_ctrl_Tx_en ? ~ch_empty : '0;
    assign head_empty = ch_empty[cur_ch_q];
    assign head_data  = ch_rdata[{cur_ch_q, 3'b000} +: 8];

    // Search starts just after the last granted channel and wraps modulo N_CH.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = {1'b0, ptr_q} + (CH_W+1)'(i);
            if (cand >= (CH_W+1)'(N_CH)) begin
                cand = cand - (CH_W+1)'(N_CH);
            end
            if (!found && req[cand[CH_W-1:0]]) begin
                found = 1'b1;
                win   = cand[CH_W-1:0];
            end
        end
    end

    always_ff @(posedge glb_clk or posedge glb_rst) begin
        if (glb_rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= CH_W'(N_CH - 1);
            cur_ch_q <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cur_ch_q <= cur_ch_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cur_ch_d = cur_ch_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        ch_r_en  = '0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    ptr_d    = win;
                    cur_ch_d = win;
                    cnt_d    = '0;
                    mode_d   = Cfg_ctrl_protocal_en;
                    state_d  = Cfg_ctrl_protocal_en ? S_ADDR : S_PAYLOAD;
                end
            end
            S_ADDR: begin
                tx_valid = 1'b1;
                tx_data  = ADDR_BASE | 8'(cur_ch_q);
                if (core_ready) begin
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                tx_valid = ~head_empty;
                tx_data  = head_data;
                // An empty FIFO closes the frame, even with zero payload bytes sent.
                if (head_empty) begin
                    state_d = mode_q ? S_ENDF : S_IDLE;
                end else if (core_ready) begin
                    ch_r_en[cur_ch_q] = 1'b1;
                    cnt_d             = cnt_q + CNT_W'(1);
                    if ((cnt_q + CNT_W'(1)) == CNT_W'(MAX_BURST)) begin
                        state_d = mode_q ? S_ENDF : S_IDLE;
                    end
                end
            end
            S_ENDF: begin
                tx_valid = 1'b1;
                tx_data  = END_BYTE;
                if (core_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign cur_ch      = cur_ch_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Bench for uart_tx_frame_arbiter: FWFT FIFO models per channel, byte scoreboard,
// a table of single-channel frames and hand-written multi-cycle sequences.
module tb_uart_tx_frame_arbiter;

    localparam int N_CH = 4;

    logic              glb_clk;
    logic              glb_rst;
    logic              Cfg_ctrl_Tx_en;
    logic              Cfg_ctrl_protocal_en;
    logic [N_CH-1:0]   ch_empty;
    logic [N_CH*8-1:0] ch_rdata;
    logic [N_CH-1:0]   ch_r_en;
    logic              core_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              busy;
    logic [1:0]        cur_ch;
    logic [1:0]        dbg_state_o;

    uart_tx_frame_arbiter dut (
        .glb_clk              (glb_clk),
        .glb_rst              (glb_rst),
        .Cfg_ctrl_Tx_en       (Cfg_ctrl_Tx_en),
        .Cfg_ctrl_protocal_en (Cfg_ctrl_protocal_en),
        .ch_empty             (ch_empty),
        .ch_rdata             (ch_rdata),
        .ch_r_en              (ch_r_en),
        .core_ready           (core_ready),
        .tx_valid             (tx_valid),
        .tx_data              (tx_data),
        .busy                 (busy),
        .cur_ch               (cur_ch),
        .dbg_state_o          (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial glb_clk = 1'b0;
    always #5 glb_clk = ~glb_clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- FWFT FIFO models ----------------
    logic [7:0] mem [N_CH][64];
    logic [7:0] rd_ptr [N_CH];
    logic [7:0] wr_ptr [N_CH];
    logic       flush;

    always @(posedge glb_clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (flush) rd_ptr[i] <= wr_ptr[i];
            else if (ch_r_en[i]) rd_ptr[i] <= rd_ptr[i] + 8'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ch_empty[i]        = (rd_ptr[i] == wr_ptr[i]);
            ch_rdata[i*8 +: 8] = mem[i][rd_ptr[i][5:0]];
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    int         busy_cnt = 0;
    int         pops [N_CH] = '{default: 0};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge glb_clk) begin
        if (!glb_rst) begin
            if (busy) busy_cnt++;
            if (ch_r_en != '0) begin
                for (int i = 0; i < N_CH; i++) if (ch_r_en[i]) pops[i]++;
                check("pop_onehot_on_xfer", 32'($onehot(ch_r_en) && tx_valid && core_ready), 32'd1);
            end
            if (tx_valid && core_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL tx_unexpected: got %0h expected no byte", tx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("tx_byte", 32'(tx_data), 32'(exp_b));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_fifo(input int ch, input logic [7:0] b);
        mem[ch][wr_ptr[ch][5:0]] = b;
        wr_ptr[ch] = wr_ptr[ch] + 8'd1;
    endtask

    task automatic do_reset();
        glb_rst = 1'b1;
        flush   = 1'b1;
        repeat (2) @(posedge glb_clk);
        #1;
        glb_rst = 1'b0;
        flush   = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge glb_clk);
            if (!busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
        @(posedge glb_clk);
        #1;
    endtask

    task automatic step();
        @(posedge glb_clk);
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int         ch;
        logic       mode;
        int         n;
        logic [7:0] d0;
        logic [7:0] exp_addr;
        int         exp_busy;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        bit         ok;
        logic [7:0] b;
        int         b0;
        int         p0;

        vecs[0] = '{ch: 1, mode: 1'b1, n: 3,  d0: 8'h11, exp_addr: 8'h81, exp_busy: 6};
        vecs[1] = '{ch: 0, mode: 1'b0, n: 2,  d0: 8'h40, exp_addr: 8'h00, exp_busy: 3};
        vecs[2] = '{ch: 2, mode: 1'b1, n: 16, d0: 8'h01, exp_addr: 8'h82, exp_busy: 18};
        vecs[3] = '{ch: 3, mode: 1'b1, n: 1,  d0: 8'h7E, exp_addr: 8'h83, exp_busy: 4};

        for (int i = 0; i < N_CH; i++) wr_ptr[i] = 8'd0;
        glb_rst              = 1'b1;
        flush                = 1'b1;
        Cfg_ctrl_Tx_en       = 1'b1;
        Cfg_ctrl_protocal_en = 1'b1;
        core_ready           = 1'b1;
        do_reset();

        // Reset values
        @(negedge glb_clk);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_ch_r_en", 32'(ch_r_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_cur_ch", 32'(cur_ch), 32'd0);
        check("rst_state", 32'(dbg_state_o), 32'd0);
        step();

        // Single-channel frames from the table
        for (int v = 0; v < 4; v++) begin
            Cfg_ctrl_protocal_en = vecs[v].mode;
            b0 = busy_cnt;
            p0 = pops[vecs[v].ch];
            if (vecs[v].mode) exp_q.push_back(vecs[v].exp_addr);
            for (int k = 0; k < vecs[v].n; k++) begin
                b = vecs[v].d0 + 8'(k * 17);
                push_fifo(vecs[v].ch, b);
                exp_q.push_back(b);
            end
            if (vecs[v].mode) exp_q.push_back(8'h0A);
            @(negedge glb_clk);
            check("idle_before_grant", 32'(tx_valid), 32'd0);
            @(negedge glb_clk);
            check("first_valid_latency", 32'(tx_valid), 32'd1);
            wait_done("vec_done");
            check("vec_busy_cycles", 32'(busy_cnt - b0), 32'(vecs[v].exp_busy));
            check("vec_pops", 32'(pops[vecs[v].ch] - p0), 32'(vecs[v].n));
            check("vec_cur_ch_hold", 32'(cur_ch), 32'(vecs[v].ch));
        end

        // Round-robin order after reset: 0, 2, 3
        do_reset();
        Cfg_ctrl_protocal_en = 1'b1;
        exp_q = '{8'h80, 8'hC0, 8'h0A, 8'h82, 8'hC2, 8'h0A, 8'h83, 8'hC3, 8'h0A};
        push_fifo(0, 8'hC0);
        push_fifo(2, 8'hC2);
        push_fifo(3, 8'hC3);
        wait_done("rr_done");
        check("rr_last_ch", 32'(cur_ch), 32'd3);

        // Burst limit: ch0 20 bytes split 16 + 4 around ch1's frame
        do_reset();
        p0 = pops[0];
        b0 = pops[1];
        exp_q.push_back(8'h80);
        for (int k = 0; k < 16; k++) exp_q.push_back(8'(k));
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h80);
        for (int k = 16; k < 20; k++) exp_q.push_back(8'(k));
        exp_q.push_back(8'h0A);
        for (int k = 0; k < 20; k++) push_fifo(0, 8'(k));
        push_fifo(1, 8'h55);
        wait_done("burst_done");
        check("burst_pops_ch0", 32'(pops[0] - p0), 32'd20);
        check("burst_pops_ch1", 32'(pops[1] - b0), 32'd1);

        // Raw mode with mid-frame protocol toggle
        do_reset();
        Cfg_ctrl_protocal_en = 1'b0;
        exp_q = '{8'hA5, 8'h5A};
        push_fifo(3, 8'hA5);
        push_fifo(3, 8'h5A);
        step();
        Cfg_ctrl_protocal_en = 1'b1;
        check("raw_in_payload", 32'(dbg_state_o), 32'd2);
        wait_done("raw_done");

        // Back-pressure in ADDR and in PAYLOAD
        do_reset();
        core_ready = 1'b0;
        exp_q = '{8'h81, 8'h11, 8'h22, 8'h33, 8'h0A};
        push_fifo(1, 8'h11);
        push_fifo(1, 8'h22);
        push_fifo(1, 8'h33);
        step();
        ok = 1'b1;
        repeat (5) begin
            @(negedge glb_clk);
            if (!(tx_valid && tx_data == 8'h81 && ch_r_en == '0)) ok = 1'b0;
            step();
        end
        check("addr_stall_hold", 32'(ok), 32'd1);
        core_ready = 1'b1;
        step();
        core_ready = 1'b0;
        ok = 1'b1;
        repeat (5) begin
            @(negedge glb_clk);
            if (!(tx_valid && tx_data == 8'h11 && ch_r_en == '0)) ok = 1'b0;
            step();
        end
        check("payload_stall_hold", 32'(ok), 32'd1);
        core_ready = 1'b1;
        wait_done("stall_done");

        // Tx_en dropped mid-payload: frame completes, then no new grant
        do_reset();
        exp_q.push_back(8'h82);
        for (int k = 0; k < 6; k++) begin
            push_fifo(2, 8'hE0 + 8'(k));
            exp_q.push_back(8'hE0 + 8'(k));
        end
        exp_q.push_back(8'h0A);
        step();
        step();
        step();
        Cfg_ctrl_Tx_en = 1'b0;
        wait_done("txen_off_done");
        push_fifo(0, 8'h99);
        ok = 1'b1;
        repeat (8) begin
            @(negedge glb_clk);
            if (busy || tx_valid) ok = 1'b0;
        end
        check("idle_while_disabled", 32'(ok), 32'd1);
        step();
        Cfg_ctrl_Tx_en = 1'b1;
        exp_q = '{8'h80, 8'h99, 8'h0A};
        wait_done("reenable_done");

        // Reset mid-payload: outputs drop at once, no end byte
        do_reset();
        exp_q = '{8'h81, 8'hD0};
        for (int k = 0; k < 4; k++) push_fifo(1, 8'hD0 + 8'(k));
        step();
        step();
        step();
        #2;
        check("pre_reset_valid", 32'(tx_valid), 32'd1);
        glb_rst = 1'b1;
        flush   = 1'b1;
        #1;
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        check("midrst_ch_r_en", 32'(ch_r_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge glb_clk);
        #1;
        glb_rst = 1'b0;
        flush   = 1'b0;
        check("midrst_partial_frame", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge glb_clk);
        check("midrst_stays_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
